proc_ctrl: RTL and testbench



---
 rtl/proc_ctrl.sv | 165 ++++++++++++++++
 tb/tb_proc_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/proc_ctrl.sv
// rtl/proc_ctrl.sv - control sequencer for the simple 16-bit processor datapath
//
// Purpose:
//   Latches a 9-bit instruction from din in T0 and drives the bus-source
//   selects, register write enables and add/sub ALU controls over 1-3
//   execute timesteps. done pulses in the final step of every instruction.
//
// Instruction word (IR[8:0]): op = IR[8:6], X = IR[5:3], Y = IR[2:0]
//   000 mv   RX,RY  : T1 R[Y] -> R[X]
//   001 mvi  RX,#D  : T1 din -> R[X]
//   010 add  RX,RY  : T1 A <= R[X]; T2 G <= A+R[Y]; T3 R[X] <= G
//   011 sub  RX,RY  : as add with G <= A-R[Y]
//   100 mvnz RX,RY  : (PROC_CTRL_MVNZ_EN only) mv when g_nz=1, else no write
//   1xx otherwise   : NOP, done in T1
//
// Optional feature macro: PROC_CTRL_MVNZ_EN
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   run         in   start request, sampled only in T0
//   din[DW]     in   instruction in T0; immediate data in T1 of mvi
//   g_nz        in   G-nonzero flag (mvnz only)
//   ir_ena      out  IR load strobe
//   r_sel[NREG] out  one-hot bus source select R0..R7
//   din_sel     out  bus source = din
//   g_sel       out  bus source = G
//   r_ena[NREG] out  one-hot register write enable R0..R7
//   A_ena       out  load A from bus
//   Add_SubNot  out  1 = A+bus, 0 = A-bus
//   G_ena       out  load G with the add/sub result
//   done        out  one-cycle completion pulse

module proc_ctrl #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [DW-1:0]   din,
  input  logic            g_nz,
  output logic            ir_ena,
  output logic [NREG-1:0] r_sel,
  output logic            din_sel,
  output logic            g_sel,
  output logic [NREG-1:0] r_ena,
  output logic            A_ena,
  output logic            Add_SubNot,
  output logic            G_ena,
  output logic            done
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_e;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
`ifdef PROC_CTRL_MVNZ_EN
  localparam logic [2:0] OP_MVNZ = 3'b100;
`endif

  tstep_e     step_q, step_d;
  logic [8:0] ir_q, ir_d;

  logic [2:0] op, rx, ry;
  assign op = ir_q[8:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  // Upper din bits are data-only, and g_nz is dead without the mvnz option.
  logic unused_bits;
  assign unused_bits = ^{din[DW-1:9], g_nz};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= T0;
      ir_q   <= '0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
    end
  end

  always_comb begin
    step_d     = step_q;
    ir_d       = ir_q;
    ir_ena     = 1'b0;
    r_sel      = '0;
    din_sel    = 1'b0;
    g_sel      = 1'b0;
    r_ena      = '0;
    A_ena      = 1'b0;
    Add_SubNot = 1'b0;
    G_ena      = 1'b0;
    done       = 1'b0;

    case (step_q)
      T0: begin
        // Gate with rst so the strobe reads 0 while reset is held even if
        // run is already high.
        ir_ena = run & ~rst;
        if (run) begin
          ir_d   = din[8:0];
          step_d = T1;
        end
      end

      T1: begin
        case (op)
          OP_MV: begin
            r_sel[ry] = 1'b1;
            r_ena[rx] = 1'b1;
            done      = 1'b1;
            step_d    = T0;
          end
          OP_MVI: begin
            din_sel   = 1'b1;
            r_ena[rx] = 1'b1;
            done      = 1'b1;
            step_d    = T0;
          end
          OP_ADD, OP_SUB: begin
            r_sel[rx] = 1'b1;
            A_ena     = 1'b1;
            step_d    = T2;
          end
`ifdef PROC_CTRL_MVNZ_EN
          OP_MVNZ: begin
            if (g_nz) begin
              r_sel[ry] = 1'b1;
              r_ena[rx] = 1'b1;
            end
            done   = 1'b1;
            step_d = T0;
          end
`endif
          default: begin
            done   = 1'b1;
            step_d = T0;
          end
        endcase
      end

      // T2/T3 are only reachable from add/sub.
      T2: begin
        r_sel[ry]  = 1'b1;
        G_ena      = 1'b1;
        Add_SubNot = (op == OP_ADD);
        step_d     = T3;
      end

      T3: begin
        g_sel     = 1'b1;
        r_ena[rx] = 1'b1;
        done      = 1'b1;
        step_d    = T0;
      end

      default: step_d = T0;
    endcase
  end

endmodule

// File: tb/tb_proc_ctrl.sv
// tb/tb_proc_ctrl.sv - table-driven self-checking bench for proc_ctrl
module tb_proc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] din;
  logic        g_nz;
  logic        ir_ena;
  logic [7:0]  r_sel;
  logic        din_sel;
  logic        g_sel;
  logic [7:0]  r_ena;
  logic        A_ena;
  logic        Add_SubNot;
  logic        G_ena;
  logic        done;

  proc_ctrl #(.DW(16), .NREG(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .din        (din),
    .g_nz       (g_nz),
    .ir_ena     (ir_ena),
    .r_sel      (r_sel),
    .din_sel    (din_sel),
    .g_sel      (g_sel),
    .r_ena      (r_ena),
    .A_ena      (A_ena),
    .Add_SubNot (Add_SubNot),
    .G_ena      (G_ena),
    .done       (done)
  );

  always #5 clk = ~clk;

`ifdef PROC_CTRL_MVNZ_EN
  localparam bit MVNZ = 1'b1;
`else
  localparam bit MVNZ = 1'b0;
`endif

  // {ir_ena, r_sel, din_sel, g_sel, r_ena, A_ena, Add_SubNot, G_ena, done}
  typedef struct {
    logic        run;
    logic [15:0] din;
    logic        g_nz;
    logic [22:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [22:0] pk(input logic ir, input logic [7:0] rs, input logic ds,
                                     input logic gs, input logic [7:0] re, input logic a,
                                     input logic as, input logic g, input logic d);
    return {ir, rs, ds, gs, re, a, as, g, d};
  endfunction

  function automatic logic [22:0] outs();
    return {ir_ena, r_sel, din_sel, g_sel, r_ena, A_ena, Add_SubNot, G_ena, done};
  endfunction

  task automatic add_vec(input logic r, input logic [15:0] d, input logic nz, input logic [22:0] e);
    vec_t v;
    v.run = r; v.din = d; v.g_nz = nz; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [22:0] exp);
    logic [22:0] act;
    int nsel;
    act = outs();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: outputs got %06h expected %06h", name, act, exp);
    end
    nsel = $countones(r_sel) + int'(din_sel) + int'(g_sel);
    n_cmp++;
    if (nsel > 1) begin
      n_bad++;
      $display("FAIL %s bus_onehot: %0d sources active, expected at most 1", name, nsel);
    end
  endtask

  // Drive at posedge+1, sample at posedge+2, then advance one clock.
  task automatic step(input string name, input logic r, input logic [15:0] d,
                      input logic nz, input logic [22:0] e);
    run = r; din = d; g_nz = nz;
    #1;
    check(name, e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [22:0] ZERO = 23'd0;

  initial begin
    logic [22:0] mvnz_hit;
    rst = 1'b1; run = 1'b1; din = 16'h08A; g_nz = 1'b0;

    // mvi R3 (0x058), imm 0xA5
    add_vec(1'b0, 16'h000, 1'b0, ZERO);
    add_vec(1'b1, 16'h058, 1'b0, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    add_vec(1'b0, 16'h0A5, 1'b0, pk(0, 8'h00, 1, 0, 8'h08, 0, 0, 0, 1));
    add_vec(1'b0, 16'h000, 1'b0, ZERO);
    // add R1,R2 (0x08A); run high in T1/T2 must be ignored
    add_vec(1'b1, 16'h08A, 1'b0, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    add_vec(1'b1, 16'h1C0, 1'b0, pk(0, 8'h02, 0, 0, 8'h00, 1, 0, 0, 0));
    add_vec(1'b1, 16'h1C0, 1'b0, pk(0, 8'h04, 0, 0, 8'h00, 0, 1, 1, 0));
    add_vec(1'b0, 16'h1C0, 1'b0, pk(0, 8'h00, 0, 1, 8'h02, 0, 0, 0, 1));
    add_vec(1'b0, 16'h000, 1'b0, ZERO);
    // sub R7,R0 (0x0F8), run held through done -> back-to-back fetch
    add_vec(1'b1, 16'h0F8, 1'b0, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    add_vec(1'b1, 16'h000, 1'b0, pk(0, 8'h80, 0, 0, 8'h00, 1, 0, 0, 0));
    add_vec(1'b1, 16'h000, 1'b0, pk(0, 8'h01, 0, 0, 8'h00, 0, 0, 1, 0));
    add_vec(1'b1, 16'h000, 1'b0, pk(0, 8'h00, 0, 1, 8'h80, 0, 0, 0, 1));
    // mv R0,R5 (0x005), run toggled low in T1, then NOP (0x1C0)
    add_vec(1'b1, 16'h005, 1'b0, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    add_vec(1'b0, 16'h1C0, 1'b0, pk(0, 8'h20, 0, 0, 8'h01, 0, 0, 0, 1));
    add_vec(1'b1, 16'h1C0, 1'b0, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    add_vec(1'b1, 16'h10A, 1'b0, pk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1));
    // op 100 (0x10A) with g_nz=1 then g_nz=0
    mvnz_hit = MVNZ ? pk(0, 8'h04, 0, 0, 8'h02, 0, 0, 0, 1) : pk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1);
    add_vec(1'b1, 16'h10A, 1'b0, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    add_vec(1'b0, 16'h000, 1'b1, mvnz_hit);
    add_vec(1'b1, 16'h10A, 1'b1, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    add_vec(1'b0, 16'h000, 1'b0, pk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1));
    // add R2,R2 (0x092): X==Y
    add_vec(1'b1, 16'h092, 1'b0, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    add_vec(1'b0, 16'h000, 1'b0, pk(0, 8'h04, 0, 0, 8'h00, 1, 0, 0, 0));
    add_vec(1'b0, 16'h000, 1'b0, pk(0, 8'h04, 0, 0, 8'h00, 0, 1, 1, 0));
    add_vec(1'b0, 16'h000, 1'b0, pk(0, 8'h00, 0, 1, 8'h04, 0, 0, 0, 1));
    // NOP op 101 (0x16D)
    add_vec(1'b1, 16'h16D, 1'b0, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    add_vec(1'b0, 16'h000, 1'b0, pk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1));
    add_vec(1'b0, 16'h000, 1'b0, ZERO);

    // Reset held with run high: everything must read 0.
    #12;
    check("reset_hold", ZERO);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].run, vecs[i].din, vecs[i].g_nz, vecs[i].exp);
    end

    // Reset in T2 of add R1,R2 aborts it with no writeback.
    step("abort_t0", 1'b1, 16'h08A, 1'b0, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    step("abort_t1", 1'b0, 16'h000, 1'b0, pk(0, 8'h02, 0, 0, 8'h00, 1, 0, 0, 0));
    run = 1'b1;
    #1;
    check("abort_t2", pk(0, 8'h04, 0, 0, 8'h00, 0, 1, 1, 0));
    rst = 1'b1;
    #1;
    check("abort_rst_async", ZERO);
    @(posedge clk);
    #1;
    check("abort_rst_held", ZERO);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step($sformatf("abort_idle%0d", i), 1'b0, 16'h000, 1'b0, ZERO);
    end
    // IR was cleared; a fresh mvi runs normally.
    step("post_rst_fetch", 1'b1, 16'h058, 1'b0, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    step("post_rst_mvi", 1'b0, 16'h0A5, 1'b0, pk(0, 8'h00, 1, 0, 8'h08, 0, 0, 0, 1));
    step("post_rst_idle", 1'b0, 16'h000, 1'b0, ZERO);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
